mix_columns_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 43 ++++
 rtl/mix_column_word.sv | 54 +++++
 rtl/mix_columns_iter.sv | 104 ++++++++++
 tb/tb_mix_columns_iter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
package aes_pkg;

  localparam logic [7:0]  AES_POLY = 8'h1b;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned STATE_W  = 128;
  localparam int unsigned NUM_COLS = 4;

  typedef logic [BYTE_W-1:0] byte_t;

  // Row 0 byte sits in the MSBs of a column.
  typedef struct packed {
    byte_t b0;
    byte_t b1;
    byte_t b2;
    byte_t b3;
  } column_t;

  // Element [3] is column 0 so the packed value matches the bus layout.
  typedef logic [NUM_COLS-1:0][COL_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  function automatic byte_t xtime(byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p = '0;
    byte_t x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational single-column MixColumns; inverse matrix with MIX_COLUMNS_INV_EN.
module mix_column_word
  import aes_pkg::*;
(
  input  column_t col_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic    inv,
`endif
  output column_t col_out_c
);

  byte_t a   [4];
  byte_t x1  [4];
  byte_t m3  [4];
  byte_t res [4];
`ifdef MIX_COLUMNS_INV_EN
  byte_t x2 [4];
  byte_t x4 [4];
  byte_t m9 [4];
  byte_t mb [4];
  byte_t md [4];
  byte_t me [4];
`endif

  // One xtime chain per byte feeds both the forward and inverse coefficients.
  always_comb begin
    a[0] = col_in.b0;
    a[1] = col_in.b1;
    a[2] = col_in.b2;
    a[3] = col_in.b3;
    for (int i = 0; i < 4; i++) begin
      x1[i] = xtime(a[i]);
      m3[i] = x1[i] ^ a[i];
`ifdef MIX_COLUMNS_INV_EN
      x2[i] = xtime(x1[i]);
      x4[i] = xtime(x2[i]);
      m9[i] = x4[i] ^ a[i];
      mb[i] = x4[i] ^ x1[i] ^ a[i];
      md[i] = x4[i] ^ x2[i] ^ a[i];
      me[i] = x4[i] ^ x2[i] ^ x1[i];
`endif
    end
    for (int r = 0; r < 4; r++) begin
`ifdef MIX_COLUMNS_INV_EN
      if (inv) res[r] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      else     res[r] = x1[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
`else
      res[r] = x1[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
`endif
    end
    col_out_c = {res[0], res[1], res[2], res[3]};
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns, COLS_PER_CYCLE columns per BUSY cycle.
// Optional inverse mode via MIX_COLUMNS_INV_EN (adds the inv port).
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] data_out
`ifdef MIX_COLUMNS_INV_EN
  ,
  input  logic               inv
`endif
);

  localparam int unsigned CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(COLS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_COLS - COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $fatal(1, "mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  fsm_t             state;
  logic [CNT_W-1:0] cnt;
  aes_state_t       work;
  logic [CNT_W-1:0] idx     [COLS_PER_CYCLE];
  column_t          col_in  [COLS_PER_CYCLE];
  column_t          col_res [COLS_PER_CYCLE];
`ifdef MIX_COLUMNS_INV_EN
  logic             inv_q;
`endif

  // Lanes j cover columns cnt+j; column i lives in work[3-i].
  for (genvar j = 0; j < int'(COLS_PER_CYCLE); j++) begin : g_lane
    assign idx[j]    = cnt + CNT_W'(j);
    assign col_in[j] = work[CNT_W'(3) - idx[j]];
    mix_column_word u_word (
      .col_in    (col_in[j]),
`ifdef MIX_COLUMNS_INV_EN
      .inv       (inv_q),
`endif
      .col_out_c (col_res[j])
    );
  end

  assign data_out = work;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            work     <= aes_state_t'(data_in);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_BUSY;
`ifdef MIX_COLUMNS_INV_EN
            inv_q    <= inv;
`endif
          end
        end
        ST_BUSY: begin
          for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
            work[CNT_W'(3) - idx[j]] <= col_res[j];
          end
          cnt <= cnt + CNT_STEP;
          if (cnt == CNT_LAST) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter at COLS_PER_CYCLE = 1, 2 and 4 with a scoreboard per instance.
module tb_mix_columns_iter;

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] din  [3];
  logic [127:0] dout [3];
`ifdef MIX_COLUMNS_INV_EN
  logic         inv_s [3];
`endif

  logic [127:0] exp_q [3][$];
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           stop_tgl = 0;

  always #5 clk = ~clk;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout required completion", name);
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mix_columns_iter #(.COLS_PER_CYCLE(32'(1) << k)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[k]),
      .in_ready  (ir[k]),
      .data_in   (din[k]),
      .out_valid (ov[k]),
      .out_ready (ordy[k]),
      .data_out  (dout[k])
`ifdef MIX_COLUMNS_INV_EN
      ,
      .inv       (inv_s[k])
`endif
    );

    // A handshake completes on the following rising edge; compare now while data is stable.
    always @(negedge clk) begin
      if (rst_n && ov[k] && ordy[k]) begin
        if (exp_q[k].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_%0d: got %h required no output", k, dout[k]);
        end else begin
          check($sformatf("data_out_%0d", k), dout[k], exp_q[k].pop_front());
        end
      end
    end
  end

  // Reference by polynomial long division, independent of any xtime chain.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(logic [127:0] s, logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int b = 0; b < 4; b++)
          acc = acc ^ gmul(cf[(b - row + 4) % 4], s[127 - 32*c - 8*b -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic send(input int k, input logic [127:0] d, input logic [127:0] e);
    int t = 0;
    forever begin
      @(posedge clk); #1;
      if (ir[k]) break;
      t++;
      if (t > 200) begin
        fail_now($sformatf("in_ready_wait_%0d", k));
        return;
      end
    end
    iv[k]  = 1'b1;
    din[k] = d;
    exp_q[k].push_back(e);
    @(posedge clk); #1;
    iv[k] = 1'b0;
    check($sformatf("accepted_%0d", k), 128'(ir[k]), 128'(0));
  endtask

  task automatic drain(input int k);
    for (int t = 0; t < 1000; t++) begin
      if (exp_q[k].size() == 0) return;
      @(posedge clk); #1;
    end
    fail_now($sformatf("drain_%0d", k));
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int lat = 4 >> k;
    ordy[k] = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
    inv_s[k] = v.inv;
`endif
    send(k, v.din, v.exp);
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk); #1;
      check($sformatf("out_valid_lat_%0d_e%0d", k, e), 128'(ov[k]), 128'(e == lat));
      check($sformatf("in_ready_busy_%0d_e%0d", k, e), 128'(ir[k]), 128'(0));
    end
    @(posedge clk); #1;
    check($sformatf("out_valid_drop_%0d", k), 128'(ov[k]), 128'(0));
    check($sformatf("in_ready_back_%0d", k), 128'(ir[k]), 128'(1));
  endtask

  localparam logic [127:0] V1_IN    = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

  initial begin
    vec_t         vecs [$];
    logic [127:0] d;

    vecs.push_back('{V1_IN, 1'b0, V1_OUT});
    vecs.push_back('{FIPS_IN, 1'b0, FIPS_OUT});
    vecs.push_back('{128'h0, 1'b0, 128'h0});
    vecs.push_back('{{4{32'hffffffff}}, 1'b0, {4{32'hffffffff}}});
    vecs.push_back('{128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0,
                     model(128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0)});
`ifdef MIX_COLUMNS_INV_EN
    vecs.push_back('{FIPS_OUT, 1'b1, FIPS_IN});
    vecs.push_back('{V1_OUT, 1'b1, V1_IN});
    vecs.push_back('{FIPS_IN, 1'b0, FIPS_OUT});
`endif

    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; din[k] = '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_s[k] = 1'b0;
`endif
    end
    rst_n = 1'b0;
    #23 rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_in_ready_%0d", k), 128'(ir[k]), 128'(1));
      check($sformatf("rst_out_valid_%0d", k), 128'(ov[k]), 128'(0));
      check($sformatf("rst_data_out_%0d", k), dout[k], 128'h0);
    end

    // Directed vectors with latency check on every lane width.
    for (int k = 0; k < 3; k++)
      foreach (vecs[i]) run_vec(k, vecs[i]);
    for (int k = 0; k < 3; k++) drain(k);

    // Backpressure: result must hold and extra inputs must be ignored.
    ordy[0] = 1'b0;
    send(0, FIPS_IN, FIPS_OUT);
    for (int t = 0; t < 10 && !ov[0]; t++) begin @(posedge clk); #1; end
    check("bp_out_valid_rise", 128'(ov[0]), 128'(1));
    for (int t = 0; t < 10; t++) begin
      iv[0]  = 1'b1;
      din[0] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check("bp_out_valid_hold", 128'(ov[0]), 128'(1));
      check("bp_data_out_hold", dout[0], FIPS_OUT);
      check("bp_in_ready_low", 128'(ir[0]), 128'(0));
    end
    iv[0] = 1'b0; din[0] = '0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 128'(ov[0]), 128'(0));
    check("bp_release_in_ready", 128'(ir[0]), 128'(1));
    send(0, V1_IN, V1_OUT);
    drain(0);

    // Reset after two BUSY cycles discards the in-flight state.
    send(0, FIPS_IN, FIPS_OUT);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    void'(exp_q[0].pop_back());
    check("mid_rst_in_ready", 128'(ir[0]), 128'(1));
    check("mid_rst_out_valid", 128'(ov[0]), 128'(0));
    check("mid_rst_data_out", dout[0], 128'h0);
    #2 rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      check("post_rst_no_output", 128'(ov[0]), 128'(0));
    end

    // Streaming with random gaps and random backpressure.
`ifdef MIX_COLUMNS_INV_EN
    inv_s[0] = 1'b0;
`endif
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          d = {$urandom, $urandom, $urandom, $urandom};
          send(0, d, model(d, 1'b0));
        end
        drain(0);
        stop_tgl = 1;
      end
      begin
        while (!stop_tgl) begin
          @(posedge clk); #1;
          ordy[0] = 1'($urandom_range(0, 1));
        end
        ordy[0] = 1'b1;
      end
    join

    for (int k = 0; k < 3; k++)
      check($sformatf("scoreboard_empty_%0d", k), 128'(exp_q[k].size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
